// File: rtl/neuron_argmax.sv
// Output-layer accumulator and argmax: sums PARTS partial sums per neuron over CLASSES neurons
// and reports each neuron total plus the index/value of the largest one (ties keep the lower index).
module neuron_argmax #(
   parameter int PARTS   = 4,
   parameter int CLASSES = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [19:0] s_in,
   output logic        busy,
   output logic        acc_valid,
   output logic [23:0] acc_out,
   output logic [3:0]  class_idx,
   output logic        done,
   output logic [3:0]  best_idx,
   output logic [23:0] best_val
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [3:0] LAST_PART   = 4'(PARTS - 1);
   localparam logic [3:0] LAST_NEURON = 4'(CLASSES - 1);

   state_t      state, state_next;
   logic [3:0]  part_cnt;
   logic [3:0]  neuron_cnt;
   logic [23:0] acc;
   logic [23:0] total;
   logic        part_end;
   logic        last_neuron;
   logic        take_best;
   logic        busy_d;
   logic        done_d;

   always_comb begin
      total       = acc + {4'd0, s_in};
      part_end    = (state == ACCUM) && in_valid && (part_cnt == LAST_PART);
      last_neuron = (neuron_cnt == LAST_NEURON);
      // Neuron 0 always seeds the running best, so an all-zero result still reports index 0.
      take_best   = (total > best_val) || (neuron_cnt == 4'd0);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: the default assignment at the top of each always_comb prevents latch inference.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start) state_next = ACCUM;
         ACCUM:   if (part_end && last_neuron) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered status flags are loaded from the next-state decode so they line up with the state.
   always_comb begin
      busy_d = (state_next != IDLE);
      done_d = (state_next == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         part_cnt   <= '0;
         neuron_cnt <= '0;
         acc        <= '0;
         busy       <= 1'b0;
         acc_valid  <= 1'b0;
         acc_out    <= '0;
         class_idx  <= '0;
         done       <= 1'b0;
         best_idx   <= '0;
         best_val   <= '0;
      end else begin
         busy      <= busy_d;
         done      <= done_d;
         acc_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  part_cnt   <= '0;
                  neuron_cnt <= '0;
                  acc        <= '0;
                  best_idx   <= '0;
                  best_val   <= '0;
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  if (part_end) begin
                     acc_out    <= total;
                     class_idx  <= neuron_cnt;
                     acc_valid  <= 1'b1;
                     acc        <= '0;
                     part_cnt   <= '0;
                     neuron_cnt <= last_neuron ? 4'd0 : neuron_cnt + 4'd1;
                     if (take_best) begin
                        best_val <= total;
                        best_idx <= neuron_cnt;
                     end
                  end else begin
                     acc      <= total;
                     part_cnt <= part_cnt + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_argmax.sv
// Randomised self-checking bench for neuron_argmax: neuron totals and argmax are derived from a
// parts table with plain sums, then compared with the acc_valid stream and final result.
module tb_neuron_argmax;

   localparam int PARTS   = 4;
   localparam int CLASSES = 10;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [19:0] s_in;
   logic        busy;
   logic        acc_valid;
   logic [23:0] acc_out;
   logic [3:0]  class_idx;
   logic        done;
   logic [3:0]  best_idx;
   logic [23:0] best_val;

   neuron_argmax #(.PARTS(PARTS), .CLASSES(CLASSES)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .s_in      (s_in),
      .busy      (busy),
      .acc_valid (acc_valid),
      .acc_out   (acc_out),
      .class_idx (class_idx),
      .done      (done),
      .best_idx  (best_idx),
      .best_val  (best_val)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] val;
      logic [3:0]  idx;
   } acc_ev_t;

   int          total_cnt = 0;
   int          bad_cnt   = 0;
   acc_ev_t     acc_q[$];
   int          done_cnt;
   int          busy_drops;
   logic [19:0] parts   [CLASSES][PARTS];
   logic [23:0] exp_tot [CLASSES];
   logic [3:0]  exp_best_idx;
   logic [23:0] exp_best_val;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Observe outputs mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      acc_ev_t ev;
      if (acc_valid) begin
         ev.val = acc_out;
         ev.idx = class_idx;
         acc_q.push_back(ev);
      end
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: each total is the plain sum of its parts; best is the first index holding the maximum.
   task automatic compute_model();
      int unsigned mx;
      mx = 0;
      for (int n = 0; n < CLASSES; n++) begin
         int unsigned s;
         s = 0;
         for (int p = 0; p < PARTS; p++) s += parts[n][p];
         exp_tot[n] = 24'(s);
         if (s > mx) mx = s;
      end
      for (int n = CLASSES - 1; n >= 0; n--)
         if (exp_tot[n] == 24'(mx)) exp_best_idx = 4'(n);
      exp_best_val = 24'(mx);
   endtask

   // mode 0: neuron 7 dominant, 1: tie 2/5, 2: all max, 3: random, 4: all zero, 5: small values (ties)
   task automatic fill(input int mode);
      for (int n = 0; n < CLASSES; n++)
         for (int p = 0; p < PARTS; p++)
            case (mode)
               0:       parts[n][p] = (n == 7) ? 20'h00100 : 20'h00001;
               1:       parts[n][p] = (n == 2 || n == 5) ? 20'h3FFFF : 20'h00000;
               2:       parts[n][p] = 20'hFFFFF;
               3:       parts[n][p] = 20'($urandom);
               4:       parts[n][p] = 20'h00000;
               default: parts[n][p] = 20'($urandom_range(3, 0));
            endcase
      compute_model();
   endtask

   task automatic drive(input int n_neurons, input int smin, input int smax, input bit noise);
      acc_q.delete();
      done_cnt   = 0;
      busy_drops = 0;
      start    = 1'b1;
      in_valid = noise;
      s_in     = 20'($urandom);
      tick();
      start = 1'b0;
      for (int n = 0; n < n_neurons; n++)
         for (int p = 0; p < PARTS; p++) begin
            int stalls;
            stalls = $urandom_range(smax, smin);
            for (int k = 0; k < stalls; k++) begin
               in_valid = 1'b0;
               start    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
               s_in     = 20'($urandom);
               if (!busy) busy_drops++;
               tick();
            end
            start    = 1'b0;
            in_valid = 1'b1;
            s_in     = parts[n][p];
            if (!busy) busy_drops++;
            tick();
         end
      in_valid = 1'b0;
      s_in     = '0;
   endtask

   task automatic check_run(input string tag);
      check({tag, ".n_acc"}, 32'(acc_q.size()), CLASSES);
      for (int i = 0; i < CLASSES && i < acc_q.size(); i++) begin
         check($sformatf("%s.val%0d", tag, i), 32'(acc_q[i].val), 32'(exp_tot[i]));
         check($sformatf("%s.idx%0d", tag, i), 32'(acc_q[i].idx), i);
      end
      check({tag, ".done_cnt"}, 32'(done_cnt), 1);
      check({tag, ".best_idx"}, 32'(best_idx), 32'(exp_best_idx));
      check({tag, ".best_val"}, 32'(best_val), 32'(exp_best_val));
      check({tag, ".busy_run"}, 32'(busy_drops), 0);
      check({tag, ".busy_end"}, 32'(busy), 0);
   endtask

   task automatic run_full(input string tag, input int smin, input int smax, input bit noise);
      drive(CLASSES, smin, smax, noise);
      repeat (3) tick();
      check_run(tag);
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".busy"},      32'(busy),      0);
      check({tag, ".acc_valid"}, 32'(acc_valid), 0);
      check({tag, ".acc_out"},   32'(acc_out),   0);
      check({tag, ".class_idx"}, 32'(class_idx), 0);
      check({tag, ".done"},      32'(done),      0);
      check({tag, ".best_idx"},  32'(best_idx),  0);
      check({tag, ".best_val"},  32'(best_val),  0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      s_in     = '0;
      done_cnt = 0;
      repeat (2) tick();
      check_zero("reset");
      rst = 1'b0;
      tick();

      fill(0); run_full("base", 0, 0, 1'b0);
      check("base.class7", 32'(exp_tot[7]), 32'h000400);
      fill(1); run_full("tie", 0, 0, 1'b0);
      fill(2); run_full("max", 0, 0, 1'b0);
      fill(0); run_full("stall", 3, 3, 1'b0);

      // Idle traffic must not disturb anything; the previous result stays visible.
      acc_q.delete();
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         s_in     = 20'($urandom);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check("idle.n_acc",    32'(acc_q.size()), 0);
      check("idle.busy",     32'(busy),         0);
      check("idle.best_idx", 32'(best_idx),     32'(exp_best_idx));
      check("idle.best_val", 32'(best_val),     32'(exp_best_val));

      fill(3); run_full("noise", 0, 2, 1'b1);
      fill(4); run_full("zero", 0, 1, 1'b0);

      // Abort after neuron 4 completes.
      fill(3);
      drive(5, 0, 1, 1'b0);
      rst      = 1'b1;
      in_valid = 1'b1;
      s_in     = 20'($urandom);
      tick();
      rst      = 1'b0;
      in_valid = 1'b0;
      check_zero("midrst");
      repeat (4) tick();
      check("midrst.n_acc", 32'(acc_q.size()), 5);
      check("midrst.done",  32'(done_cnt),     0);
      run_full("after_rst", 0, 0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         fill((r % 2 == 0) ? 3 : 5);
         run_full($sformatf("rand%0d", r), 0, 2, 1'(r % 2));
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1);
   end

endmodule
